// File: rtl/fetcher_if.sv
// Program-memory read channel between the fetcher (master) and instruction memory (slave).
// Valid/address are held by the master until a same-cycle ready/data response arrives.
interface fetcher_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/fetcher.sv
// Instruction fetcher with a one-entry last-PC buffer: hit in 1 cycle, miss = accept cycles + 1.
// Holds the request until memory responds or TIMEOUT_CYCLES elapse, then substitutes RET.
module fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    fetcher_if.master                        mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_error
);
    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;
    localparam logic [2:0]    CORE_FETCH  = 3'b001;
    localparam logic [2:0]    CORE_DECODE = 3'b010;
    localparam logic [15:0]   CNT_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] RET_INSTR   = DW'(16'hF000);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } state_t;

    state_t        state_q, state_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          buf_vld_q, buf_vld_d;
    logic [AW-1:0] buf_pc_q, buf_pc_d;
    logic [DW-1:0] buf_dat_q, buf_dat_d;
    logic          hit;

    // A flush sampled on the same edge as the hit check forces a miss.
    assign hit = buf_vld_q && (buf_pc_q == current_pc) && !flush;

    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        buf_vld_d = buf_vld_q && !flush;
        buf_pc_d  = buf_pc_q;
        buf_dat_d = buf_dat_q;
        case (state_q)
            S_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (hit) begin
                        instr_d = buf_dat_q;
                        state_d = S_FETCHED;
                    end else begin
                        vld_d   = 1'b1;
                        addr_d  = current_pc;
                        cnt_d   = 16'd0;
                        state_d = S_FETCHING;
                    end
                end
            end
            S_FETCHING: begin
                if (mem.mem_read_ready) begin
                    instr_d   = mem.mem_read_data;
                    vld_d     = 1'b0;
                    buf_vld_d = !flush;
                    buf_pc_d  = addr_q;
                    buf_dat_d = mem.mem_read_data;
                    state_d   = S_FETCHED;
                end else if (cnt_q == CNT_LAST) begin
                    instr_d = RET_INSTR;
                    vld_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FETCHED;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            vld_q     <= 1'b0;
            addr_q    <= '0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
            buf_vld_q <= 1'b0;
            buf_pc_q  <= '0;
            buf_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            buf_vld_q <= buf_vld_d;
            buf_pc_q  <= buf_pc_d;
            buf_dat_q <= buf_dat_d;
        end
    end

    assign mem.mem_read_valid   = vld_q;
    assign mem.mem_read_address = addr_q;
    assign fetcher_state        = state_q;
    assign instruction          = instr_q;
    assign fetch_error          = err_q;
endmodule

// File: tb/tb_fetcher.sv
// Scenario-driven bench for fetcher; expected instructions are queued when a fetch is issued.
module tb_fetcher;
    localparam int TO = 4;
    localparam logic [2:0] FETCH  = 3'b001;
    localparam logic [2:0] DECODE = 3'b010;
    localparam logic [2:0] ST_IDLE = 3'b000, ST_FETCHING = 3'b001, ST_FETCHED = 3'b010;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        fetch_error;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    fetcher_if #(.AW(8), .DW(16)) mif ();

    fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_pc(current_pc),
        .flush(flush),
        .mem(mif.master),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .fetch_error(fetch_error)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; core_state = 3'b000; current_pc = 8'h00; flush = 1'b0;
        mif.mem_read_ready = 1'b0; mif.mem_read_data = 16'h0000;
        step; step;
        checks++; if (fetcher_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%b exp=%b", fetcher_state, ST_IDLE); end
        checks++; if (mif.mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", mif.mem_read_valid); end
        checks++; if (mif.mem_read_address !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", mif.mem_read_address); end
        checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h exp=0000", instruction); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", fetch_error); end
        reset = 1'b1; step;
        core_state = FETCH; current_pc = 8'h22; step; core_state = 3'b000;
        checks++; if (mif.mem_read_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", mif.mem_read_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mif.mem_read_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got=%b exp=0", mif.mem_read_valid); end
        checks++; if (fetcher_state !== ST_IDLE) begin errors++; $display("FAIL async_reset_state got=%b exp=%b", fetcher_state, ST_IDLE); end
        checks++; if (instruction !== 16'h0000 || fetch_error !== 1'b0) begin errors++; $display("FAIL async_reset_outs got=%h/%b exp=0000/0", instruction, fetch_error); end
        step; reset = 1'b1; step;
    endtask

    task automatic test_miss;
        core_state = FETCH; current_pc = 8'h05; exp_q.push_back(16'h3123);
        step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_FETCHING || mif.mem_read_valid !== 1'b1) begin errors++; $display("FAIL miss_req got=%b/%b exp=%b/1", fetcher_state, mif.mem_read_valid, ST_FETCHING); end
        checks++; if (mif.mem_read_address !== 8'h05) begin errors++; $display("FAIL miss_addr got=%h exp=05", mif.mem_read_address); end
        for (int i = 0; i < 2; i++) begin
            step;
            checks++; if (mif.mem_read_valid !== 1'b1 || mif.mem_read_address !== 8'h05) begin errors++; $display("FAIL miss_hold cyc=%0d got=%b/%h exp=1/05", i, mif.mem_read_valid, mif.mem_read_address); end
        end
        mif.mem_read_ready = 1'b1; mif.mem_read_data = 16'h3123;
        step; mif.mem_read_ready = 1'b0; mif.mem_read_data = 16'h0000;
        checks++; if (fetcher_state !== ST_FETCHED || mif.mem_read_valid !== 1'b0) begin errors++; $display("FAIL miss_done got=%b/%b exp=%b/0", fetcher_state, mif.mem_read_valid, ST_FETCHED); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL miss_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL miss_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_IDLE || instruction !== 16'h3123) begin errors++; $display("FAIL miss_decode got=%b/%h exp=%b/3123", fetcher_state, instruction, ST_IDLE); end
    endtask

    task automatic test_hit;
        core_state = FETCH; current_pc = 8'h05; exp_q.push_back(16'h3123);
        step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_FETCHED || mif.mem_read_valid !== 1'b0) begin errors++; $display("FAIL hit_state got=%b/%b exp=%b/0", fetcher_state, mif.mem_read_valid, ST_FETCHED); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL hit_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL hit_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
        flush = 1'b1; step; flush = 1'b0;
        core_state = FETCH; current_pc = 8'h05; step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_FETCHING || mif.mem_read_valid !== 1'b1) begin errors++; $display("FAIL flush_miss got=%b/%b exp=%b/1", fetcher_state, mif.mem_read_valid, ST_FETCHING); end
        exp_q.push_back(16'h3123);
        mif.mem_read_ready = 1'b1; mif.mem_read_data = 16'h3123;
        step; mif.mem_read_ready = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL refill_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL refill_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
    endtask

    task automatic test_races;
        core_state = FETCH; current_pc = 8'h60; exp_q.push_back(16'h1ABC);
        step; core_state = 3'b000;
        repeat (TO - 1) step;
        checks++; if (fetcher_state !== ST_FETCHING) begin errors++; $display("FAIL race_pre_state got=%b exp=%b", fetcher_state, ST_FETCHING); end
        mif.mem_read_ready = 1'b1; mif.mem_read_data = 16'h1ABC;
        step; mif.mem_read_ready = 1'b0;
        checks++; if (fetcher_state !== ST_FETCHED || fetch_error !== 1'b0) begin errors++; $display("FAIL race_ready_wins got=%b/%b exp=%b/0", fetcher_state, fetch_error, ST_FETCHED); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL race_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL race_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
        core_state = FETCH; current_pc = 8'h70; exp_q.push_back(16'h2777);
        step; core_state = 3'b000;
        mif.mem_read_ready = 1'b1; mif.mem_read_data = 16'h2777; flush = 1'b1;
        step; mif.mem_read_ready = 1'b0; flush = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL flushfill_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL flushfill_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
        core_state = FETCH; current_pc = 8'h70; step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_FETCHING || mif.mem_read_valid !== 1'b1) begin errors++; $display("FAIL flushfill_miss got=%b/%b exp=%b/1", fetcher_state, mif.mem_read_valid, ST_FETCHING); end
        exp_q.push_back(16'h2777);
        mif.mem_read_ready = 1'b1; mif.mem_read_data = 16'h2777;
        step; mif.mem_read_ready = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fill70_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL fill70_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
    endtask

    task automatic test_timeout;
        core_state = FETCH; current_pc = 8'h40; exp_q.push_back(16'hF000);
        step; core_state = 3'b000;
        for (int i = 0; i < TO - 1; i++) begin
            step;
            checks++; if (fetcher_state !== ST_FETCHING || mif.mem_read_valid !== 1'b1) begin errors++; $display("FAIL to_wait cyc=%0d got=%b/%b exp=%b/1", i, fetcher_state, mif.mem_read_valid, ST_FETCHING); end
        end
        step;
        checks++; if (fetcher_state !== ST_FETCHED || mif.mem_read_valid !== 1'b0) begin errors++; $display("FAIL to_state got=%b/%b exp=%b/0", fetcher_state, mif.mem_read_valid, ST_FETCHED); end
        checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL to_error got=%b exp=1", fetch_error); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL to_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL to_instr got=%h exp=%h", instruction, exp_w); end end
        core_state = DECODE; step; core_state = 3'b000;
        core_state = FETCH; current_pc = 8'h70; exp_q.push_back(16'h2777);
        step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_FETCHED || mif.mem_read_valid !== 1'b0) begin errors++; $display("FAIL to_buf_kept got=%b/%b exp=%b/0", fetcher_state, mif.mem_read_valid, ST_FETCHED); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL to_hit_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL to_hit_instr got=%h exp=%h", instruction, exp_w); end end
        checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", fetch_error); end
        core_state = DECODE; step; core_state = 3'b000;
    endtask

    task automatic test_handshake;
        core_state = FETCH; current_pc = 8'h70; exp_q.push_back(16'h2777);
        step; step; step;
        checks++; if (fetcher_state !== ST_FETCHED || instruction !== 16'h2777) begin errors++; $display("FAIL hs_hold got=%b/%h exp=%b/2777", fetcher_state, instruction, ST_FETCHED); end
        core_state = DECODE; step; core_state = 3'b000;
        checks++; if (fetcher_state !== ST_IDLE) begin errors++; $display("FAIL hs_decode got=%b exp=%b", fetcher_state, ST_IDLE); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL hs_sb got=empty exp=entry"); end
        else begin exp_w = exp_q.pop_front(); if (instruction !== exp_w) begin errors++; $display("FAIL hs_instr got=%h exp=%h", instruction, exp_w); end end
        mif.mem_read_ready = 1'b1; mif.mem_read_data = 16'hBEEF;
        step; step; mif.mem_read_ready = 1'b0;
        checks++; if (fetcher_state !== ST_IDLE || mif.mem_read_valid !== 1'b0 || instruction !== 16'h2777) begin errors++; $display("FAIL stray_ready got=%b/%b/%h exp=%b/0/2777", fetcher_state, mif.mem_read_valid, instruction, ST_IDLE); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_miss;
        test_hit;
        test_races;
        test_timeout;
        test_handshake;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
